// File: rtl/padbid_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : padbid_xfer_ctrl
// Brief    : Half-duplex controller for a WIDTH-bit PADBID pad bus. Writes
//            drive the pads for DRIVE_CYC cycles, then release them for a
//            TURN_CYC turnaround. Reads release the pads for SETTLE_CYC
//            cycles, capture pad_c and return it over a valid/ready handshake.
//            Optional macro PADBID_LOOPBACK_CHK_EN adds a sticky loopback
//            comparator on the last drive cycle (err). Without it, err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module padbid_xfer_ctrl #(
    parameter int WIDTH      = 4,
    parameter int DRIVE_CYC  = 2,
    parameter int TURN_CYC   = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_oen,
    input  logic [WIDTH-1:0] pad_c,
    output logic             busy,
    output logic             err
);

    // The counter is sized for the largest cycle parameter.
    localparam int c_MAX_A = (DRIVE_CYC > TURN_CYC) ? DRIVE_CYC : TURN_CYC;
    localparam int c_MAX   = (c_MAX_A > SETTLE_CYC) ? c_MAX_A : SETTLE_CYC;
    localparam int c_CW    = $clog2(c_MAX + 1);

    // Reload values are "cycles - 1" because the phase ends on the edge
    // where the counter reads zero.
    localparam logic [c_CW-1:0] c_DRIVE_LD  = c_CW'(DRIVE_CYC - 1);
    localparam logic [c_CW-1:0] c_TURN_LD   = c_CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam logic [c_CW-1:0] c_SETTLE_LD = c_CW'(SETTLE_CYC - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DRIVE  = 3'd1;
    localparam logic [2:0] c_ST_TURN   = 3'd2;
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_RESP   = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0] w_pad_i_nxt;
    logic [WIDTH-1:0] w_pad_oen_nxt;
    logic             w_rd_valid_nxt;
    logic [WIDTH-1:0] w_rd_data_nxt;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);
    assign wr_ready   = (r_state == c_ST_IDLE);
    assign busy       = (r_state != c_ST_IDLE);

    // State register and phase counter.
    always_ff @(posedge CK) begin
        if (!RN) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter reload/decrement.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (wr_valid) begin
                    w_state_nxt = c_ST_DRIVE;
                    w_cnt_nxt   = c_DRIVE_LD;
                end else if (rd_req) begin
                    w_state_nxt = c_ST_SETTLE;
                    w_cnt_nxt   = c_SETTLE_LD;
                end
            end
            c_ST_DRIVE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = (TURN_CYC == 0) ? c_ST_IDLE : c_ST_TURN;
                    w_cnt_nxt   = c_TURN_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_TURN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_RESP: begin
                if (rd_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Next values of the registered pad and read-return outputs.
    always_comb begin
        w_pad_i_nxt    = pad_i;
        w_pad_oen_nxt  = pad_oen;
        w_rd_valid_nxt = rd_valid;
        w_rd_data_nxt  = rd_data;
        case (r_state)
            c_ST_IDLE: begin
                if (wr_valid) begin
                    w_pad_i_nxt   = wr_data;
                    w_pad_oen_nxt = '0;
                end else begin
                    w_pad_i_nxt   = '0;
                    w_pad_oen_nxt = '1;
                end
            end
            c_ST_DRIVE: begin
                if (w_cnt_zero) begin
                    w_pad_i_nxt   = '0;
                    w_pad_oen_nxt = '1;
                end
            end
            c_ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_rd_data_nxt  = pad_c;
                    w_rd_valid_nxt = 1'b1;
                end
            end
            c_ST_RESP: begin
                if (rd_ready) begin
                    w_rd_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_pad_i_nxt   = '0;
                w_pad_oen_nxt = '1;
            end
        endcase
    end

    // Output registers; reset releases the pads and drops any pending read.
    always_ff @(posedge CK) begin
        if (!RN) begin
            pad_i    <= '0;
            pad_oen  <= '1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            pad_i    <= w_pad_i_nxt;
            pad_oen  <= w_pad_oen_nxt;
            rd_valid <= w_rd_valid_nxt;
            rd_data  <= w_rd_data_nxt;
        end
    end

`ifdef PADBID_LOOPBACK_CHK_EN
    logic r_err;
    logic w_lb_mismatch;

    // The pad must read back what it drives by the last drive cycle.
    assign w_lb_mismatch = (r_state == c_ST_DRIVE) && w_cnt_zero && (pad_c != pad_i);

    // Sticky loopback error, cleared only by reset.
    always_ff @(posedge CK) begin
        if (!RN) begin
            r_err <= 1'b0;
        end else if (w_lb_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_padbid_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_padbid_xfer_ctrl
// Brief    : Scoreboard bench for padbid_xfer_ctrl (WIDTH=4, DRIVE_CYC=2,
//            TURN_CYC=1, SETTLE_CYC=2). Expected drives and read words are
//            queued by the stimulus and popped by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_padbid_xfer_ctrl;

    logic       CK = 1'b0;
    logic       RN;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_data;
    logic       rd_req;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       rd_ready;
    logic [3:0] pad_i;
    logic [3:0] pad_oen;
    logic [3:0] pad_c;
    logic       busy;
    logic       err;

    typedef struct {
        logic [3:0] data;
        int         len;
    } wr_exp_t;

    wr_exp_t    q_wr[$];
    logic [3:0] q_rd[$];

    int n_cmp = 0;
    int n_err = 0;

    padbid_xfer_ctrl #(
        .WIDTH      (4),
        .DRIVE_CYC  (2),
        .TURN_CYC   (1),
        .SETTLE_CYC (2)
    ) dut (
        .CK       (CK),
        .RN       (RN),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .pad_i    (pad_i),
        .pad_oen  (pad_oen),
        .pad_c    (pad_c),
        .busy     (busy),
        .err      (err)
    );

    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected drive/read items when the DUT presents them.
    logic       mon_on = 1'b0;
    logic       in_drive = 1'b0;
    int         drive_len = 0;
    logic       prev_rd_valid = 1'b0;
    logic [3:0] held_rd = 4'h0;
    wr_exp_t    cur_wr;

    always @(negedge CK) begin
        if (mon_on) begin
            if (pad_oen === 4'h0) begin
                if (!in_drive) begin
                    in_drive  = 1'b1;
                    drive_len = 1;
                    if (q_wr.size() == 0) begin
                        chk("unexpected_drive", 32'(pad_i), 32'hFFFF);
                        cur_wr.data = 4'h0;
                        cur_wr.len  = 0;
                    end else begin
                        cur_wr = q_wr.pop_front();
                        chk("drive_data", 32'(pad_i), 32'(cur_wr.data));
                    end
                end else begin
                    drive_len++;
                    chk("drive_data_stable", 32'(pad_i), 32'(cur_wr.data));
                end
            end else if (in_drive) begin
                in_drive = 1'b0;
                chk("drive_len", 32'(drive_len), 32'(cur_wr.len));
                chk("release_oen", 32'(pad_oen), 32'hF);
            end

            if (rd_valid === 1'b1) begin
                if (!prev_rd_valid) begin
                    if (q_rd.size() == 0) begin
                        chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF);
                    end else begin
                        chk("rd_data", 32'(rd_data), 32'(q_rd.pop_front()));
                    end
                    held_rd = rd_data;
                end else begin
                    chk("rd_data_held", 32'(rd_data), 32'(held_rd));
                end
            end
            prev_rd_valid = (rd_valid === 1'b1);
        end
    end

    // Bounded wait for wr_ready; returns cycles elapsed after the current edge.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            @(posedge CK); #1;
            cyc++;
        end while (wr_ready !== 1'b1 && cyc < 20);
        if (wr_ready !== 1'b1) chk("wr_ready_timeout", 32'(wr_ready), 32'h1);
    endtask

    // Issue a write handshake with pad_c looped back to lb and expect len drive cycles.
    task automatic do_write(input logic [3:0] d, input logic [3:0] lb, input int len);
        int cyc;
        pad_c    = lb;
        wr_valid = 1'b1;
        wr_data  = d;
        q_wr.push_back('{data: d, len: len});
        @(posedge CK); #1;
        wr_valid = 1'b0;
        wr_data  = ~d;
        chk("wr_busy", 32'(busy), 32'h1);
        wait_ready(cyc);
        chk("wr_ready_latency", 32'(cyc), 32'h3);
    endtask

    initial begin
        int cyc;
        RN = 1'b0; wr_valid = 1'b0; wr_data = 4'h0;
        rd_req = 1'b0; rd_ready = 1'b0; pad_c = 4'h0;

        // 1. Reset
        @(posedge CK); #1;
        chk("rst_oen", 32'(pad_oen), 32'hF);
        chk("rst_pad_i", 32'(pad_i), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        RN = 1'b1;
        mon_on = 1'b1;
        @(posedge CK); #1;

        // 2. Write 4'hA
        do_write(4'hA, 4'hA, 2);
        chk("post_wr_oen", 32'(pad_oen), 32'hF);

        // 3. Read with backpressure
        pad_c  = 4'h5;
        rd_req = 1'b1;
        q_rd.push_back(4'h5);
        @(posedge CK); #1;
        rd_req = 1'b0;
        chk("rd_not_yet_0", 32'(rd_valid), 32'h0);
        chk("rd_oen_released", 32'(pad_oen), 32'hF);
        @(posedge CK); #1;
        chk("rd_not_yet_1", 32'(rd_valid), 32'h0);
        @(posedge CK); #1;
        chk("rd_valid_up", 32'(rd_valid), 32'h1);
        chk("rd_wr_ready_low", 32'(wr_ready), 32'h0);
        pad_c = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(posedge CK); #1;
            chk("rd_valid_held", 32'(rd_valid), 32'h1);
            chk("rd_data_bp", 32'(rd_data), 32'h5);
        end
        rd_ready = 1'b1;
        @(posedge CK); #1;
        rd_ready = 1'b0;
        chk("rd_valid_drop", 32'(rd_valid), 32'h0);
        chk("rd_busy_drop", 32'(busy), 32'h0);
        chk("rd_data_kept", 32'(rd_data), 32'h5);

        // 4. Simultaneous write and read: write wins, read dropped
        rd_req = 1'b1;
        do_write(4'hC, 4'hC, 2);
        rd_req = 1'b0;
        repeat (6) @(posedge CK);
        #1;
        chk("simul_no_rd", 32'(rd_valid), 32'h0);

        // 5. Reset during the first drive cycle
        pad_c    = 4'h6;
        wr_valid = 1'b1;
        wr_data  = 4'h6;
        q_wr.push_back('{data: 4'h6, len: 1});
        @(posedge CK); #1;
        wr_valid = 1'b0;
        chk("mid_drive_oen", 32'(pad_oen), 32'h0);
        RN = 1'b0;
        @(posedge CK); #1;
        RN = 1'b1;
        chk("mid_rst_oen", 32'(pad_oen), 32'hF);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_pad_i", 32'(pad_i), 32'h0);
        repeat (3) @(posedge CK);
        #1;
        chk("mid_rst_no_drive", 32'(pad_oen), 32'hF);
        chk("pre_lb_err", 32'(err), 32'h0);

        // 6. Loopback mismatch, then a clean write
        do_write(4'hA, 4'h8, 2);
`ifdef PADBID_LOOPBACK_CHK_EN
        chk("lb_err_set", 32'(err), 32'h1);
`else
        chk("lb_err_tied", 32'(err), 32'h0);
`endif
        do_write(4'h5, 4'h5, 2);
`ifdef PADBID_LOOPBACK_CHK_EN
        chk("lb_err_sticky", 32'(err), 32'h1);
`else
        chk("lb_err_still0", 32'(err), 32'h0);
`endif

        repeat (4) @(posedge CK);
        #1;
        chk("q_wr_empty", 32'(q_wr.size()), 32'h0);
        chk("q_rd_empty", 32'(q_rd.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
